spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave receiver/transmitter. SPI_CLK, SPI_SS and MOSI are brought into
// the CLK_IN domain through synchronizer chains, and their edges drive a
// four-state frame engine: IDLE -> LOAD -> SHIFT -> FLUSH.
// MOSI is received LSB first. MISO is sent MSB first from a holding register
// that tx_load writes.
module spi_slave_rx #(
  parameter int C           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK_IN,
  input  logic         RST,
  input  logic         SPI_CLK,
  input  logic         SPI_SS,
  input  logic         MOSI,
  output logic         MISO,
  output logic         MISO_OE,
  input  logic         CPOL,
  input  logic         CPHA,
  input  logic [C-1:0] tx_data,
  input  logic         tx_load,
  output logic         tx_ready,
  output logic [C-1:0] dout,
  output logic         valid,
  output logic         busy,
  output logic         aborted,
  output logic         underrun
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FLUSH} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, ss_fall, ss_rise;
  logic                   do_load, do_abort, do_sample, do_shift, last_bit;

  logic [C-1:0] rx_shift, tx_shift, tx_hold;
  logic [5:0]   bit_cnt;
  logic         tx_pending, first_shift, dout_pend;

  // Synchronizers and edge-detect registers. These are not reset: they keep
  // tracking the pins through RST, so leaving reset with SPI_SS already low
  // cannot be mistaken for a new falling edge.
  always_ff @(posedge CLK_IN) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SPI_SS};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    sclk_d    <= sclk_sync[SYNC_STAGES-1];
    ss_d      <= ss_sync[SYNC_STAGES-1];
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge decode. The leading edge moves away from CPOL; CPHA selects which
  // edge samples and which edge shifts.
  always_comb begin
    sclk_rise   = sclk_s & ~sclk_d;
    sclk_fall   = ~sclk_s & sclk_d;
    lead_edge   = CPOL ? sclk_fall : sclk_rise;
    trail_edge  = CPOL ? sclk_rise : sclk_fall;
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    ss_fall     = ss_d & ~ss_s;
    ss_rise     = ~ss_d & ss_s;
  end

  // State register.
  always_ff @(posedge CLK_IN) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes. An SPI_SS rise takes priority over an
  // SPI_CLK edge in the same cycle.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_abort  = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: if (ss_fall) state_nxt = LOAD;
      LOAD: begin
        do_load = 1'b1;
        if (ss_rise) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
          last_bit  = sample_edge && (bit_cnt == 6'(C-1));
          if (last_bit) state_nxt = FLUSH;
        end
      end
      FLUSH: if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter, the reply holding register and the output
  // pulses.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      tx_pending  <= 1'b0;
      bit_cnt     <= '0;
      first_shift <= 1'b0;
      dout_pend   <= 1'b0;
      dout        <= '0;
      valid       <= 1'b0;
      aborted     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      valid     <= 1'b0;
      aborted   <= do_abort;
      underrun  <= do_load & ~tx_pending;
      dout_pend <= last_bit;
      if (dout_pend) begin
        dout  <= rx_shift;
        valid <= 1'b1;
      end
      if (do_load) begin
        tx_shift    <= tx_hold;
        rx_shift    <= '0;
        bit_cnt     <= '0;
        first_shift <= 1'b1;
      end
      if (do_sample) begin
        rx_shift <= {mosi_s, rx_shift[C-1:1]};
        bit_cnt  <= bit_cnt + 6'd1;
      end
      // MISO idles low once the whole word has been sent.
      if (last_bit) begin
        tx_shift <= '0;
      end else if (do_shift) begin
        if (CPHA && first_shift) first_shift <= 1'b0;
        else                     tx_shift    <= {tx_shift[C-2:0], 1'b0};
      end
      // A new tx_load wins over the clear done in LOAD, so a word loaded
      // during LOAD is kept for the next frame.
      if (tx_load) begin
        tx_hold    <= tx_data;
        tx_pending <= 1'b1;
      end else if (do_load) begin
        tx_pending <= 1'b0;
      end
    end
  end

  assign MISO     = tx_shift[C-1];
  assign MISO_OE  = ~ss_s;
  assign busy     = (state != IDLE);
  assign tx_ready = ~tx_pending;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx. A bit-level SPI master drives each frame. A
// frame-level model tracks the reply word, the pending flag and the expected
// received word. One compare process checks dout and valid on every cycle.
module tb_spi_slave_rx;
  localparam int C  = 32;
  localparam int SS = 2;

  logic         CLK_IN = 0, RST = 1, SPI_CLK = 0, SPI_SS = 1, MOSI = 0;
  logic         CPOL = 0, CPHA = 0, tx_load = 0;
  logic [C-1:0] tx_data = '0;
  logic         MISO, MISO_OE, tx_ready, valid, busy, aborted, underrun;
  logic [C-1:0] dout;

  spi_slave_rx #(.C(C), .SYNC_STAGES(SS)) dut (
    .CLK_IN(CLK_IN), .RST(RST), .SPI_CLK(SPI_CLK), .SPI_SS(SPI_SS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .CPOL(CPOL), .CPHA(CPHA),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .dout(dout),
    .valid(valid), .busy(busy), .aborted(aborted), .underrun(underrun)
  );

  always #5 CLK_IN = ~CLK_IN;

  int checks = 0, errors = 0;
  int valid_cnt = 0, abort_cnt = 0, under_cnt = 0;

  // Frame-level model state.
  logic [C-1:0] m_hold = '0;
  logic         m_pending = 0;
  logic [C-1:0] m_dout = '0;
  logic [C-1:0] frame_exp_rx = '0;
  logic         frame_expect_valid = 0;

  task automatic check(input string name, input logic [C-1:0] act, input logic [C-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare: dout must hold the model's value, and a valid pulse
  // may only come from a frame expected to complete, carrying its word.
  always begin
    @(posedge CLK_IN); #1;
    if (RST) begin
      m_dout = '0;
    end else begin
      if (valid) begin
        valid_cnt++;
        check("valid_allowed", {31'b0, frame_expect_valid}, 32'd1);
        check("dout_on_valid", dout, frame_exp_rx);
        m_dout = frame_exp_rx;
      end else begin
        check("dout_hold", dout, m_dout);
      end
      if (aborted)  abort_cnt++;
      if (underrun) under_cnt++;
    end
  end

  task automatic wait_half(input bit ld, input logic [C-1:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_IN);
      if (i == 0 && ld) begin tx_data = w; tx_load = 1; end
      if (i == 1) tx_load = 0;
    end
  endtask

  task automatic run_frame(input int mode, input logic [C-1:0] mosi_w, input int nbits,
                           input bit pre, input logic [C-1:0] pre_w,
                           input int mid_bit, input logic [C-1:0] mid_w,
                           input int rst_bit, output logic [C-1:0] miso_w);
    logic [C-1:0] exp_tx;
    logic         exp_under, complete, got, mism;
    int           v0, a0, u0, nchk;
    miso_w = '0;
    @(negedge CLK_IN);
    CPOL = mode[1]; CPHA = mode[0]; SPI_CLK = mode[1];
    if (pre) begin
      tx_data = pre_w; tx_load = 1;
      @(negedge CLK_IN); tx_load = 0;
      m_hold = pre_w; m_pending = 1;
    end
    repeat (6) @(negedge CLK_IN);
    exp_under = ~m_pending;
    exp_tx    = m_hold;
    m_pending = 0;
    complete  = (nbits >= C) && (rst_bit < 0);
    frame_exp_rx = mosi_w;
    frame_expect_valid = complete;
    v0 = valid_cnt; a0 = abort_cnt; u0 = under_cnt;
    SPI_SS = 0;
    repeat (8) @(negedge CLK_IN);
    check("miso_oe", {31'b0, MISO_OE}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        RST = 1;
        repeat (2) @(negedge CLK_IN);
        RST = 0;
        m_hold = '0; m_pending = 0;
        break;
      end
      got = 1'bx;
      if (!CPHA) begin
        MOSI = (i < C) ? mosi_w[i] : 1'b0;
        wait_half(0, '0);
        got = MISO;
        SPI_CLK = ~CPOL;
        wait_half(i == mid_bit, mid_w);
        SPI_CLK = CPOL;
      end else begin
        SPI_CLK = ~CPOL;
        MOSI = (i < C) ? mosi_w[i] : 1'b0;
        wait_half(i == mid_bit, mid_w);
        got = MISO;
        SPI_CLK = CPOL;
        wait_half(0, '0);
      end
      if (i == mid_bit) begin m_hold = mid_w; m_pending = 1; end
      if (i < C) miso_w[C-1-i] = got;
    end
    if (!CPHA) wait_half(0, '0);
    SPI_SS = 1;
    repeat (SS + 2) @(negedge CLK_IN);
    check("busy_after_ss", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge CLK_IN);
    check("valid_count", valid_cnt - v0, complete ? 1 : 0);
    check("abort_count", abort_cnt - a0, (!complete && rst_bit < 0) ? 1 : 0);
    check("underrun_count", under_cnt - u0, {31'b0, exp_under});
    check("tx_ready", {31'b0, tx_ready}, {31'b0, ~m_pending});
    nchk = (nbits < C) ? nbits : C;
    if (rst_bit >= 0 && rst_bit < nchk) nchk = rst_bit;
    mism = 0;
    for (int b = 0; b < nchk; b++)
      if (miso_w[C-1-b] !== exp_tx[C-1-b]) mism = 1;
    checks++;
    if (mism) begin
      errors++;
      $display("FAIL miso_word: got %h expected %h over top %0d bits", miso_w, exp_tx, nchk);
    end
    frame_expect_valid = 0;
  endtask

  initial begin
    logic [C-1:0] mw, mw1;
    int           r, nb, mb;
    repeat (4) @(negedge CLK_IN);
    RST = 0;
    @(negedge CLK_IN);
    check("rst_dout", dout, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_miso", {31'b0, MISO}, 32'd0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_pulses", {30'b0, aborted, underrun}, 32'd0);
    check("rst_miso_oe", {31'b0, MISO_OE}, 32'd0);

    // The basic frame in all four CPOL/CPHA modes.
    for (int m = 0; m < 4; m++) begin
      run_frame(m, 32'h1234_5678, C, 1, 32'hA5A5_0F0F, -1, '0, -1, mw);
      check("mode_dout", dout, 32'h1234_5678);
      check("mode_miso", mw, 32'hA5A5_0F0F);
    end

    // Back-to-back frames without a reload: the second frame underruns and
    // repeats the retained word.
    run_frame(1, 32'h0BAD_F00D, C, 1, 32'h3C3C_C3C3, -1, '0, -1, mw1);
    run_frame(2, 32'h5555_AAAA, C, 0, '0, -1, '0, -1, mw);
    check("b2b_miso1", mw1, 32'h3C3C_C3C3);
    check("b2b_miso2", mw, 32'h3C3C_C3C3);

    // Abort after 13 bits: dout keeps the previous frame's word.
    run_frame(0, 32'hDEAD_BEEF, 13, 1, 32'h1111_2222, -1, '0, -1, mw);
    check("abort_dout", dout, 32'h5555_AAAA);

    // Reset at bit 20, then a full new frame.
    run_frame(3, 32'h7777_7777, C, 1, 32'h9999_8888, -1, '0, 20, mw);
    run_frame(3, 32'hFFFF_FFFF, C, 0, '0, -1, '0, -1, mw);
    check("rst_frame_dout", dout, 32'hFFFF_FFFF);
    check("rst_frame_miso", mw, 32'h0);

    // 40 clocks with SPI_SS low: only the first 32 count.
    run_frame(1, 32'h0F1E_2D3C, 40, 1, 32'h8001_7FFE, -1, '0, -1, mw);
    check("long_dout", dout, 32'h0F1E_2D3C);

    // Randomized frames, some with a reload while the frame is in flight.
    for (int k = 0; k < 14; k++) begin
      r  = $urandom_range(0, 5);
      nb = (r == 3) ? $urandom_range(1, C - 1) :
           (r == 4) ? C + $urandom_range(1, 8) : C;
      mb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nb - 1) : -1;
      if (nb < 2) mb = -1;
      run_frame($urandom_range(0, 3), $urandom, nb, $urandom_range(0, 1) == 1,
                $urandom, mb, $urandom, -1, mw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
